// File: rtl/simple_bus_master_if.sv
// Command/response and bus signals of simple_bus_master, grouped for port connection.
// master = the bus-master block's view, slave = the client/slave environment's view.
interface simple_bus_master_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          iCMD_VALID;
    logic          oCMD_READY;
    logic          iCMD_WE;
    logic [AW-1:0] iCMD_ADR;
    logic [DW-1:0] iCMD_DAT;
    logic          oRSP_VALID;
    logic          iRSP_READY;
    logic [DW-1:0] oRSP_DAT;
    logic          oRSP_ERR;
    logic [AW-1:0] oADR;
    logic [DW-1:0] oDAT;
    logic [DW-1:0] iDAT;
    logic          oWE;
    logic          oSTB;
    logic          iACK;
    logic          oBUSY;

    modport master (
        input  iCMD_VALID, iCMD_WE, iCMD_ADR, iCMD_DAT, iRSP_READY, iDAT, iACK,
        output oCMD_READY, oRSP_VALID, oRSP_DAT, oRSP_ERR, oADR, oDAT, oWE, oSTB, oBUSY
    );

    modport slave (
        output iCMD_VALID, iCMD_WE, iCMD_ADR, iCMD_DAT, iRSP_READY, iDAT, iACK,
        input  oCMD_READY, oRSP_VALID, oRSP_DAT, oRSP_ERR, oADR, oDAT, oWE, oSTB, oBUSY
    );
endinterface

// File: rtl/simple_bus_master.sv
// Single-transaction strobe/ack bus master: IDLE -> BUS -> RESP.
// Optional strobe timeout enabled by defining SIMPLE_BUS_MASTER_TIMEOUT_EN.
module simple_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    simple_bus_master_if.master  bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("simple_bus_master: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;

`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.iCMD_VALID) begin
                    state_d = S_BUS;
                    adr_d   = bus.iCMD_ADR;
                    dat_d   = bus.iCMD_WE ? bus.iCMD_DAT : '0;
                    we_d    = bus.iCMD_WE;
                    stb_d   = 1'b1;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUS: begin
                // ACK is checked first so it wins over a timeout on the same edge
                if (bus.iACK) begin
                    state_d     = S_RESP;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : bus.iDAT;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = S_RESP;
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = '0;
                        rsp_err_d   = 1'b1;
                    end
`endif
                end
            end
            S_RESP: begin
                if (bus.iRSP_READY) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // READY/BUSY decode from state only; READY is also masked while reset is held
    assign bus.oCMD_READY = (state_q == S_IDLE) && !iRST;
    assign bus.oBUSY      = (state_q != S_IDLE);
    assign bus.oSTB       = stb_q;
    assign bus.oADR       = adr_q;
    assign bus.oDAT       = dat_q;
    assign bus.oWE        = we_q;
    assign bus.oRSP_VALID = rsp_valid_q;
    assign bus.oRSP_DAT   = rsp_dat_q;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
    assign bus.oRSP_ERR   = rsp_err_q;
`else
    assign bus.oRSP_ERR   = 1'b0;
`endif

endmodule
